// File: rtl/uart_tx_serializer_pkg.sv
// Shared UART transmitter definitions: FSM state encoding, LCR bit positions,
// default FIFO occupancy width and small word-length / parity helpers.
// Pure constants and functions; no timing or flow control of its own.
package uart_tx_serializer_pkg;

  // Occupancy count width for a 16-entry TX FIFO (0..16 needs 5 bits).
  localparam int FIFO_CNT_W_DEF = 5;

  // Line control register bit positions.
  localparam int LCR_WLEN_LO = 0;  // [1:0] word length code, 0..3 => 5..8 bits
  localparam int LCR_WLEN_HI = 1;
  localparam int LCR_STB     = 2;  // extra stop
  localparam int LCR_PEN     = 3;  // parity enable
  localparam int LCR_EPS     = 4;  // even parity select
  localparam int LCR_SP      = 5;  // stick parity
  localparam int LCR_BRK     = 6;  // break control

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POP    = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } tx_state_t;

  // Mask selecting the data bits that belong to the configured word length.
  function automatic logic [7:0] wlen_mask(input logic [1:0] wlen);
    return 8'hFF >> (2'd3 - wlen);
  endfunction

  // Final parity bit from the raw XOR of the data bits.
  // Stick parity forces the complement of the even-select bit; otherwise
  // even parity sends the XOR itself and odd parity sends its inverse.
  function automatic logic parity_out(input logic raw_xor, input logic eps,
                                      input logic sp);
    if (sp) return ~eps;
    return eps ? raw_xor : ~raw_xor;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops words from the TX FIFO and shifts them out as
// start / 5..8 data (LSB first) / optional parity / 1, 1.5 or 2 stop bits.
// Latency: POP one clk after a non-empty FIFO is seen; every bit = 16 enable
// ticks. Backpressure: none upstream beyond the single-clk pop strobe.
//
// Ports:
//   clk          system clock, all state on its rising edge
//   wb_rst_i     asynchronous active-low reset
//   enable       16x baud tick, one clk wide
//   lcr[7:0]     line control (word length, stop, parity, break)
//   tf_data_out  TX FIFO head word, valid when tf_count != 0
//   tf_count     TX FIFO occupancy
//   tf_pop       one-clk pop strobe to the TX FIFO
//   stx_o        registered serial line, idle high
//   tx_busy      high whenever a frame is in progress (state != IDLE)
module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int FIFO_CNT_W = FIFO_CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  wb_rst_i,
  input  logic                  enable,
  input  logic [7:0]            lcr,
  input  logic [7:0]            tf_data_out,
  input  logic [FIFO_CNT_W-1:0] tf_count,
  output logic                  tf_pop,
  output logic                  stx_o,
  output logic                  tx_busy
);

  tx_state_t  state_q, state_d;
  logic [3:0] tick_q, tick_d;     // enable ticks within the current bit
  logic [2:0] bit_q, bit_d;       // data bit index; in STOP, 16-tick chunk index
  logic [7:0] shift_q, shift_d;   // data being shifted out, LSB on the line
  logic [5:0] lcr_q, lcr_d;       // frame format frozen at POP
  logic       par_q, par_d;       // raw XOR of the frame's data bits
  logic       line_d;

  logic       fifo_has;
  logic       bit_end;
  logic       stop_end;
  logic [2:0] last_bit;
  logic       unused_lcr7;

  assign unused_lcr7 = lcr[7];

  assign fifo_has = (tf_count != '0);
  assign bit_end  = enable && (tick_q == 4'd15);
  assign last_bit = 3'd4 + {1'b0, lcr_q[LCR_WLEN_HI:LCR_WLEN_LO]};

  // Stop length: 16 ticks, or with extra stop 24 (5-bit words) / 32 ticks.
  // Beyond 16 ticks the chunk index bit_q[0] extends the 4-bit tick counter.
  always_comb begin
    stop_end = (tick_q == 4'd15);
    if (lcr_q[LCR_STB]) begin
      if (lcr_q[LCR_WLEN_HI:LCR_WLEN_LO] == 2'd0)
        stop_end = bit_q[0] && (tick_q == 4'd7);
      else
        stop_end = bit_q[0] && (tick_q == 4'd15);
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    lcr_d   = lcr_q;
    par_d   = par_q;
    case (state_q)
      S_IDLE: begin
        if (fifo_has) state_d = S_POP;
      end
      S_POP: begin
        lcr_d   = lcr[5:0];
        shift_d = tf_data_out;
        par_d   = ^(tf_data_out & wlen_mask(lcr[LCR_WLEN_HI:LCR_WLEN_LO]));
        tick_d  = 4'd0;
        bit_d   = 3'd0;
        state_d = S_START;
      end
      S_START: begin
        if (enable) tick_d = tick_q + 4'd1;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (enable) tick_d = tick_q + 4'd1;
        if (bit_end) begin
          if (bit_q == last_bit) begin
            bit_d   = 3'd0;
            state_d = lcr_q[LCR_PEN] ? S_PARITY : S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (enable) tick_d = tick_q + 4'd1;
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (enable) tick_d = tick_q + 4'd1;
        if (enable && stop_end) begin
          tick_d  = 4'd0;
          bit_d   = 3'd0;
          // Back-to-back frames go straight to POP with no idle clk.
          state_d = fifo_has ? S_POP : S_IDLE;
        end else if (bit_end) begin
          bit_d = bit_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line value is computed from the next state so the registered stx_o lines
  // up with the state register. Break overrides the line only.
  always_comb begin
    line_d = 1'b1;
    case (state_d)
      S_START:  line_d = 1'b0;
      S_DATA:   line_d = shift_d[0];
      S_PARITY: line_d = parity_out(par_q, lcr_q[LCR_EPS], lcr_q[LCR_SP]);
      default:  line_d = 1'b1;
    endcase
    if (lcr[LCR_BRK]) line_d = 1'b0;
  end

  always_ff @(posedge clk or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= S_IDLE;
      tick_q  <= 4'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      lcr_q   <= 6'd0;
      par_q   <= 1'b0;
      stx_o   <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      lcr_q   <= lcr_d;
      par_q   <= par_d;
      stx_o   <= line_d;
    end
  end

  assign tf_pop  = (state_q == S_POP);
  assign tx_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: a queue models the TX FIFO, enable
// ticks every 4 clks, and the line is recorded once per consumed tick.
module tb_uart_tx_serializer;

  logic       clk;
  logic       wb_rst_i;
  logic       enable;
  logic [7:0] lcr;
  logic [7:0] tf_data_out;
  logic [4:0] tf_count;
  logic       tf_pop;
  logic       stx_o;
  logic       tx_busy;

  uart_tx_serializer #(.FIFO_CNT_W(5)) dut (
    .clk(clk), .wb_rst_i(wb_rst_i), .enable(enable), .lcr(lcr),
    .tf_data_out(tf_data_out), .tf_count(tf_count), .tf_pop(tf_pop),
    .stx_o(stx_o), .tx_busy(tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] fifo [$];
  logic       trace [$];   // line value during each tick consumed mid-frame
  logic       exp_q [$];   // expected trace
  logic       eb [10];
  int         n_cmp, n_bad, pop_cnt, bad_pop, phase, n, gap;
  bit         pop_pending, en_run;

  function automatic void sync_fifo();
    tf_count    = 5'(fifo.size());
    tf_data_out = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endfunction

  function automatic logic trace_at(input int i);
    return (i < trace.size()) ? trace[i] : 1'bx;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bits(input string tag, input int nb);
    for (int k = 0; k < nb; k++)
      chk($sformatf("%s_bit%0d", tag, k), 32'(trace_at(16 * k + 8)), 32'(eb[k]));
  endtask

  // Reference frame: start, data LSB first, optional parity, stop ticks.
  task automatic add_frame(input logic [7:0] l, input logic [7:0] d);
    int   wl;
    int   st;
    logic p;
    wl = 5 + int'(l[1:0]);
    p  = 1'b0;
    repeat (16) exp_q.push_back(1'b0);
    for (int i = 0; i < wl; i++) begin
      p = p ^ d[i];
      repeat (16) exp_q.push_back(d[i]);
    end
    if (l[3]) begin
      if (l[5])      p = ~l[4];
      else if (!l[4]) p = ~p;
      repeat (16) exp_q.push_back(p);
    end
    st = !l[2] ? 16 : ((wl == 5) ? 24 : 32);
    repeat (st) exp_q.push_back(1'b1);
  endtask

  task automatic cmp_trace(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (trace_at(i) !== exp_q[i]) bad++;
    chk({tag, "_trace"}, 32'(bad), 32'd0);
  endtask

  task automatic start_frame(input logic [7:0] l, input logic [7:0] d);
    trace.delete();
    exp_q.delete();
    pop_cnt = 0;
    lcr = l;
    fifo.push_back(d);
    sync_fifo();
    add_frame(l, d);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk); #1;
      k++;
    end while ((tx_busy || fifo.size() != 0 || pop_pending) && k < 4000);
    chk({tag, "_done"}, 32'(k < 4000), 32'd1);
  endtask

  task automatic wait_ticks(input int cnt, input string tag);
    int k;
    k = 0;
    while (trace.size() < cnt && k < 4000) begin
      @(negedge clk); #1;
      k++;
    end
    chk({tag, "_reach"}, 32'(k < 4000), 32'd1);
  endtask

  // FIFO pop, tick generation and line recording, all on the falling edge.
  initial begin
    phase = 0;
    forever begin
      @(negedge clk);
      if (pop_pending) begin
        void'(fifo.pop_front());
        pop_pending = 1'b0;
      end
      if (tf_pop === 1'b1) begin
        pop_cnt++;
        if (fifo.size() == 0) bad_pop++;
        else pop_pending = 1'b1;
      end
      sync_fifo();
      enable = en_run && (phase == 0);
      phase  = (phase + 1) % 4;
      if (enable && tx_busy === 1'b1 && tf_pop !== 1'b1) trace.push_back(stx_o);
    end
  end

  initial begin
    wb_rst_i = 1'b0;
    enable   = 1'b0;
    lcr      = 8'h03;
    en_run   = 1'b1;
    sync_fifo();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stx", 32'(stx_o), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_pop", 32'(tf_pop), 32'd0);

    // 8N1 0xA5, word already waiting while reset is held.
    start_frame(8'h03, 8'hA5);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_hold_pop", 32'(tf_pop), 32'd0);
    chk("rst_hold_cnt", 32'(fifo.size()), 32'd1);
    wb_rst_i = 1'b1;
    #1;
    chk("rel_pop", 32'(tf_pop), 32'd0);
    wait_idle("8n1");
    chk("8n1_len", 32'(trace.size()), 32'd160);
    chk("8n1_pops", 32'(pop_cnt), 32'd1);
    eb = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    chk_bits("8n1", 10);
    cmp_trace("8n1");

    // 7E1 0x41: 1000001 LSB first, even parity 0.
    start_frame(8'h1A, 8'h41);
    wait_idle("7e1");
    chk("7e1_len", 32'(trace.size()), 32'd160);
    eb = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    chk_bits("7e1", 10);
    cmp_trace("7e1");

    // 5-bit word, extra stop => 24 stop ticks.
    start_frame(8'h04, 8'h15);
    wait_idle("5x");
    chk("5x_len", 32'(trace.size()), 32'd120);
    eb = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    chk_bits("5x", 7);
    cmp_trace("5x");

    // 8-bit word, extra stop => 32 stop ticks.
    start_frame(8'h07, 8'h15);
    wait_idle("8x");
    chk("8x_len", 32'(trace.size()), 32'd176);
    cmp_trace("8x");

    // Stick parity: 0x3B forces 0, 0x2B forces 1.
    start_frame(8'h3B, 8'h01);
    wait_idle("stk0");
    chk("stk0_len", 32'(trace.size()), 32'd176);
    chk("stk0_par", 32'(trace_at(152)), 32'd0);
    cmp_trace("stk0");
    start_frame(8'h2B, 8'h01);
    wait_idle("stk1");
    chk("stk1_par", 32'(trace_at(152)), 32'd1);
    cmp_trace("stk1");

    // Three words back-to-back.
    trace.delete();
    exp_q.delete();
    pop_cnt = 0;
    lcr = 8'h03;
    fifo.push_back(8'h11);
    fifo.push_back(8'h22);
    fifo.push_back(8'h33);
    sync_fifo();
    add_frame(8'h03, 8'h11);
    add_frame(8'h03, 8'h22);
    add_frame(8'h03, 8'h33);
    n = 0;
    gap = 0;
    while (tx_busy !== 1'b1 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    while (trace.size() < 480 && n < 4000) begin
      if (tx_busy !== 1'b1) gap++;
      @(negedge clk); #1;
      n++;
    end
    wait_idle("b2b");
    chk("b2b_len", 32'(trace.size()), 32'd480);
    chk("b2b_pops", 32'(pop_cnt), 32'd3);
    chk("b2b_gap", 32'(gap), 32'd0);
    cmp_trace("b2b");

    // Break for 20 ticks in the middle of DATA.
    start_frame(8'h03, 8'hFF);
    wait_ticks(40, "brk_on");
    lcr = 8'h43;
    wait_ticks(60, "brk_off");
    lcr = 8'h03;
    wait_idle("brk");
    for (int i = 40; i < 60; i++) exp_q[i] = 1'b0;
    chk("brk_len", 32'(trace.size()), 32'd160);
    chk("brk_mid", 32'(trace_at(50)), 32'd0);
    chk("brk_after", 32'(trace_at(70)), 32'd1);
    cmp_trace("brk");

    // Reset in the middle of a frame.
    start_frame(8'h03, 8'h00);
    wait_ticks(50, "mrst");
    chk("mrst_pre_stx", 32'(stx_o), 32'd0);
    wb_rst_i = 1'b0;
    #1;
    chk("mrst_stx", 32'(stx_o), 32'd1);
    chk("mrst_busy", 32'(tx_busy), 32'd0);
    chk("mrst_pop", 32'(tf_pop), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    wb_rst_i = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    chk("mrst_idle", 32'(tx_busy), 32'd0);
    chk("mrst_fifo", 32'(fifo.size()), 32'd0);
    chk("mrst_pops", 32'(pop_cnt), 32'd1);

    chk("no_bad_pop", 32'(bad_pop), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
